// File: rtl/mult_div.sv
// mult_div: iterative 32x32 signed multiplier / divider.
//
// Multiply produces a 64-bit product in {hi, lo}. Divide produces the
// quotient in lo and the remainder in hi. Quotients truncate toward zero
// and remainders take the sign of the dividend. Both operations take
// 32 iterations plus one sign-fix cycle. A divide by zero skips
// straight to DONE, raises div_zero and leaves hi/lo untouched.
//
// Ports:
//   clk         sole clock; all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   start_mult  request signed a*b; sampled in IDLE only; wins over start_div
//   start_div   request signed a/b; sampled in IDLE only
//   unsigned_op treat operands as unsigned (only with MULT_DIV_UNSIGNED_EN)
//   a, b        32-bit operands, captured when a start is accepted
//   hi, lo      result words: product high/low, or remainder/quotient
//   busy        high while in CALC or FIX
//   done        one-cycle pulse; results are valid from this cycle
//   div_zero    last accepted divide had b == 0; held until the next start
//
// Configuration macro: MULT_DIV_UNSIGNED_EN adds the unsigned_op input.
// Latency is the same in both builds.

module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic        unsigned_op,
`endif
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic        is_div;
    logic        neg_main;
    logic        neg_rem;
    logic [31:0] operand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic        start_any;
    logic        take_div;
    logic        b_zero;
    logic        unsigned_sel;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] prod_neg;

`ifdef MULT_DIV_UNSIGNED_EN
    assign unsigned_sel = unsigned_op;
`else
    assign unsigned_sel = 1'b0;
`endif

    assign start_any = start_mult | start_div;
    assign take_div  = start_div & ~start_mult;
    assign b_zero    = (b == 32'd0);
    assign sign_a    = a[31] & ~unsigned_sel;
    assign sign_b    = b[31] & ~unsigned_sel;
    assign mag_a     = sign_a ? (32'd0 - a) : a;
    assign mag_b     = sign_b ? (32'd0 - b) : b;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit (acc_lo[0]) is set, then shift the 65-bit
    // {carry, acc_hi, acc_lo} right. The multiplier bits shift out of
    // acc_lo as the product bits shift in.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);

    // Divide step: shift the next dividend bit into the partial
    // remainder, then try subtracting the divisor. Because the partial
    // remainder is always below the divisor, bit 32 of the difference is
    // a reliable borrow flag.
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_diff  = div_shift - {1'b0, operand};

    assign prod_neg  = 64'd0 - {acc_hi, acc_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_any) begin
                    state_next = (take_div && b_zero) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == 6'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= 6'd0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            operand  <= 32'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_any) begin
                        // The register that is not the shifter holds
                        // the multiplicand or the divisor.
                        count    <= 6'd0;
                        is_div   <= take_div;
                        neg_main <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        operand  <= take_div ? mag_b : mag_a;
                        acc_hi   <= 32'd0;
                        acc_lo   <= take_div ? mag_a : mag_b;
                        div_zero <= take_div & b_zero;
                    end
                end
                CALC: begin
                    count <= count + 6'd1;
                    if (is_div) begin
                        acc_hi <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
                        acc_lo <= {acc_lo[30:0], ~div_diff[32]};
                    end else begin
                        acc_hi <= mul_sum[32:1];
                        acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= neg_rem  ? (32'd0 - acc_hi) : acc_hi;
                        lo <= neg_main ? (32'd0 - acc_lo) : acc_lo;
                    end else begin
                        hi <= neg_main ? prod_neg[63:32] : acc_hi;
                        lo <= neg_main ? prod_neg[31:0]  : acc_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: self-checking bench for mult_div.
// Runs a table of directed vectors, hand-written reset and
// start-collision sequences, and randomized operations scored against
// a plain-arithmetic reference model. It honours MULT_DIV_UNSIGNED_EN
// when that macro is defined.

module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;
`ifdef MULT_DIV_UNSIGNED_EN
    logic        unsigned_op;
`endif

    int checks = 0;
    int errors = 0;

    // Architectural state the model expects the DUT to hold.
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;
    logic        mdl_dz = 1'b0;

    typedef struct {
        string       name;
        logic        sm;
        logic        sd;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        int          elat;
    } vec_t;

    vec_t vecs[9];

    mult_div dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
`ifdef MULT_DIV_UNSIGNED_EN
        .unsigned_op(unsigned_op),
`endif
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checkOutput("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
        end
    end

    // Reference model: results follow directly from integer arithmetic.
    task automatic modelOp(input logic sm, input logic su, input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] eh, output logic [31:0] el, output logic ed, output int elat);
        logic [63:0]        p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        eh   = mdl_hi;
        el   = mdl_lo;
        ed   = 1'b0;
        elat = 33;
        sa   = su ? {32'd0, av} : {{32{av[31]}}, av};
        sb   = su ? {32'd0, bv} : {{32{bv[31]}}, bv};
        if (sm) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (bv == 32'd0) begin
            ed   = 1'b1;
            elat = 0;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endtask

    // Present one start at the negedge before E0, then sample each
    // following negedge until done or a 40-cycle budget runs out.
    // Operands are scrambled after E0 to prove they were captured.
    task automatic applyStimulus(input logic sm, input logic sd, input logic [31:0] av, input logic [31:0] bv,
                                 input logic rel, output int lat, output logic dz0,
                                 output logic hold_ok, output logic busy_ok);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        hi0        = hi;
        lo0        = lo;
        start_mult = sm;
        start_div  = sd;
        a          = av;
        b          = bv;
        if (rel) reset = 1'b0;
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        dz0        = div_zero;
        lat        = -1;
        hold_ok    = 1'b1;
        busy_ok    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic runCheck(input string name, input logic sm, input logic sd, input logic su,
                            input logic [31:0] av, input logic [31:0] bv, input logic rel,
                            input logic [31:0] eh, input logic [31:0] el, input logic ed, input int elat);
        int    lat;
        logic  dz0;
        logic  hold_ok;
        logic  busy_ok;
        string tag;
        tag = $sformatf("%s[%s]", name, su ? "u" : "s");
`ifdef MULT_DIV_UNSIGNED_EN
        unsigned_op = su;
`endif
        applyStimulus(sm, sd, av, bv, rel, lat, dz0, hold_ok, busy_ok);
        checkOutput({tag, "_latency"}, lat, elat);
        checkOutput({tag, "_hi"}, hi, eh);
        checkOutput({tag, "_lo"}, lo, el);
        checkOutput({tag, "_div_zero"}, div_zero, ed);
        checkOutput({tag, "_div_zero_at_e0"}, dz0, ed);
        checkOutput({tag, "_hold_and_busy"}, {hold_ok, busy_ok}, 2'b11);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, {busy, done}, 2'b00);
        mdl_hi = eh;
        mdl_lo = el;
        mdl_dz = ed;
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        int          elat;
        logic        sm;
        logic        sd;
        logic        su;
        logic [31:0] av;
        logic [31:0] bv;
        int          pulses;
        logic [31:0] hi_at;
        logic [31:0] lo_at;

        vecs[0] = '{"mul_7_by_m3",      1'b1, 1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[1] = '{"div_m7_by_2",      1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[2] = '{"div_min_by_m1",    1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[3] = '{"mul_min_by_min",   1'b1, 1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[4] = '{"div_95_by_10",     1'b0, 1'b1, 32'd95,         32'd10,       32'd5,        32'd9,        1'b0, 33};
        vecs[5] = '{"div_by_zero",      1'b0, 1'b1, 32'd5,          32'd0,        32'd5,        32'd9,        1'b1, 0};
        vecs[6] = '{"both_starts",      1'b1, 1'b1, 32'd6,          32'd3,        32'd0,        32'd18,       1'b0, 33};
        vecs[7] = '{"div_7_by_m2",      1'b0, 1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vecs[8] = '{"div_m7_by_m2",     1'b0, 1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 33};

        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = 32'd0;
        b          = 32'd0;
`ifdef MULT_DIV_UNSIGNED_EN
        unsigned_op = 1'b0;
`endif
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_flags", {busy, done, div_zero}, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 9; i++) begin
            runCheck(vecs[i].name, vecs[i].sm, vecs[i].sd, 1'b0, vecs[i].av, vecs[i].bv, 1'b0,
                     vecs[i].eh, vecs[i].el, vecs[i].ed, vecs[i].elat);
        end

        // Reset in the middle of a multiply, with non-zero hi/lo/div_zero.
        $display("[TB] reset mid-operation");
        runCheck("pre_reset_div_zero", 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, mdl_hi, mdl_lo, 1'b1, 0);
        @(negedge clk);
        start_mult = 1'b1;
        a          = 32'd1000;
        b          = 32'd1000;
        @(posedge clk);
        #1 start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_hi", hi, 32'd0);
        checkOutput("midreset_lo", lo, 32'd0);
        checkOutput("midreset_flags", {busy, done, div_zero}, 3'b000);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        mdl_dz = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checkOutput("no_done_after_reset", pulses, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        runCheck("first_edge_after_reset", 1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0, 33);

        // Both starts together, then a stray start_div at E5.
        $display("[TB] start collision");
        @(negedge clk);
        start_mult = 1'b1;
        start_div  = 1'b1;
        a          = 32'd6;
        b          = 32'd3;
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        repeat (4) @(negedge clk);
        start_div = 1'b1;
        a         = 32'd100;
        b         = 32'd7;
        @(negedge clk);
        start_div = 1'b0;
        pulses    = 0;
        hi_at     = 32'hDEADBEEF;
        lo_at     = 32'hDEADBEEF;
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1) begin
                pulses++;
                hi_at = hi;
                lo_at = lo;
            end
            @(negedge clk);
        end
        checkOutput("collision_done_count", pulses, 1);
        checkOutput("collision_hi", hi_at, 32'd0);
        checkOutput("collision_lo", lo_at, 32'd18);
        mdl_hi = 32'd0;
        mdl_lo = 32'd18;
        mdl_dz = 1'b0;

`ifdef MULT_DIV_UNSIGNED_EN
        $display("[TB] unsigned operations");
        runCheck("u_mul", 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,  1'b0, 32'd1,        32'hFFFFFFFE, 1'b0, 33);
        runCheck("u_div", 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h10, 1'b0, 32'hF,        32'h0FFFFFFF, 1'b0, 33);
        runCheck("u_div_zero", 1'b0, 1'b1, 1'b1, 32'd7, 32'd0,    1'b0, 32'hF,        32'h0FFFFFFF, 1'b1, 0);
        runCheck("s_mul_sel", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
`endif

        $display("[TB] randomized operations");
        for (int i = 0; i < 30; i++) begin
            sm = 1'($urandom_range(0, 1));
            sd = !sm || ($urandom_range(0, 1) == 1);
            av = $urandom;
            case ($urandom_range(0, 7))
                0:       bv = 32'd0;
                1, 2:    bv = 32'($urandom_range(1, 20));
                3:       bv = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
                default: bv = $urandom;
            endcase
`ifdef MULT_DIV_UNSIGNED_EN
            su = 1'($urandom_range(0, 1));
`else
            su = 1'b0;
`endif
            modelOp(sm, su, av, bv, eh, el, ed, elat);
            runCheck($sformatf("random_%0d", i), sm, sd, su, av, bv, 1'b0, eh, el, ed, elat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
